// File: rtl/tea_pkg.sv
// Shared TEA definitions: constants, the round function and the
// little-endian word byte-swap helpers used at the block boundary.
package tea_pkg;

  localparam logic [31:0] DEF_DELTA  = 32'h9E3779B9;
  localparam int          DEF_ROUNDS = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] ka,
                                        input logic [31:0] kb, input logic [31:0] s);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  function automatic logic [31:0] byteswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [63:0] le32_blocks64(input logic [63:0] d);
    return {byteswap32(d[63:32]), byteswap32(d[31:0])};
  endfunction

  function automatic logic [127:0] le32_blocks128(input logic [127:0] d);
    return {byteswap32(d[127:96]), byteswap32(d[95:64]),
            byteswap32(d[63:32]),  byteswap32(d[31:0])};
  endfunction

endpackage

// File: rtl/tea_round_dec.sv
// One combinational TEA decryption round on host-order words:
// {v0,v1} and {k0,k1,k2,k3} packed MSW first.
module tea_round_dec
  import tea_pkg::*;
#(
  parameter logic [31:0] DELTA = DEF_DELTA
) (
  input  logic [63:0]  v,
  input  logic [127:0] key,
  input  logic [31:0]  sum,
  output logic [63:0]  v_next,
  output logic [31:0]  sum_next
);

  logic [31:0] v0_n, v1_n;

  // v1 is undone first because encryption updates it last.
  assign v1_n     = v[31:0]  - tea_f(v[63:32], key[63:32],  key[31:0],  sum);
  assign v0_n     = v[63:32] - tea_f(v1_n,     key[127:96], key[95:64], sum);
  assign v_next   = {v0_n, v1_n};
  assign sum_next = sum - DELTA;

endmodule

// File: rtl/tea_decrypt_iter.sv
// Iterative TEA decryption: one round per clock, valid/ready on both sides,
// 128-bit key written as two 64-bit halves.
module tea_decrypt_iter
  import tea_pkg::*;
#(
  parameter int          ROUNDS = DEF_ROUNDS,
  parameter logic [31:0] DELTA  = DEF_DELTA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        key_wr,
  input  logic        key_half,
  output logic        key_valid,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam int          CW   = $clog2(ROUNDS + 1);
  localparam logic [31:0] SUM0 = 32'(ROUNDS) * DELTA;

  state_t         state, state_nx;
  logic [127:0]   key_q, wkey;
  logic           hi_set, lo_set;
  logic [63:0]    v, v_nx;
  logic [31:0]    sum, sum_nx;
  logic [CW-1:0]  cnt;
  logic           accept, last;

  tea_round_dec #(.DELTA(DELTA)) u_round (
    .v        (v),
    .key      (wkey),
    .sum      (sum),
    .v_next   (v_nx),
    .sum_next (sum_nx)
  );

  assign key_valid = hi_set & lo_set;
  assign in_ready  = (state == IDLE) & key_valid;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CW'(ROUNDS - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      key_q    <= '0;
      wkey     <= '0;
      hi_set   <= 1'b0;
      lo_set   <= 1'b0;
      v        <= '0;
      sum      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      if (key_wr) begin
        if (key_half) begin
          key_q[127:64] <= key_in;
          hi_set        <= 1'b1;
        end else begin
          key_q[63:0]   <= key_in;
          lo_set        <= 1'b1;
        end
      end
      // Working key is the pre-edge key_q, so a same-cycle write hits the next block only.
      if (accept) begin
        v    <= le32_blocks64(in_data);
        wkey <= le32_blocks128(key_q);
        sum  <= SUM0;
        cnt  <= '0;
      end
      if (state == RUN) begin
        v   <= v_nx;
        sum <= sum_nx;
        cnt <= cnt + 1'b1;
        if (last) out_data <= le32_blocks64(v_nx);
      end
    end
  end

endmodule

// File: tb/tb_tea_decrypt_iter.sv
// Directed bench for tea_decrypt_iter; ciphertexts come from a reference
// TEA encryptor so expected outputs are the chosen plaintexts.
module tb_tea_decrypt_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key_in = '0;
  logic        key_wr = 1'b0, key_half = 1'b0;
  logic        key_valid;
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  tea_decrypt_iter dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_wr(key_wr), .key_half(key_half),
    .key_valid(key_valid), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bs(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Reference TEA encryption on byte-stream blocks/keys.
  function automatic logic [63:0] tea_enc(input logic [63:0] pt, input logic [127:0] k);
    logic [31:0] v0, v1, k0, k1, k2, k3, s;
    v0 = bs(pt[63:32]); v1 = bs(pt[31:0]);
    k0 = bs(k[127:96]); k1 = bs(k[95:64]); k2 = bs(k[63:32]); k3 = bs(k[31:0]);
    s = 32'h0;
    for (int i = 0; i < 32; i++) begin
      s  = s + 32'h9E3779B9;
      v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
      v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
    end
    return {bs(v0), bs(v1)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_key(input logic [127:0] k);
    key_wr = 1'b1; key_half = 1'b1; key_in = k[127:64];
    tick();
    key_half = 1'b0; key_in = k[63:0];
    tick();
    key_wr = 1'b0;
  endtask

  // Presents a block and returns once the accept edge has passed.
  task automatic accept_block(input logic [63:0] ct, output bit ok);
    int n;
    in_valid = 1'b1; in_data = ct; n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    ok = in_ready;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks += 5;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
    if (in_ready  !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (busy      !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (out_data  !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
  endtask

  task automatic test_key_gating();
    key_wr = 1'b1; key_half = 1'b1; key_in = 64'h0;
    tick();
    key_wr = 1'b0; in_valid = 1'b1; in_data = 64'h0A3AEA41_40A9BA94;
    tick(); tick(); tick();
    checks += 3;
    if (in_ready  !== 1'b0) begin errors++; $display("FAIL gate_in_ready got %b want 0", in_ready); end
    if (key_valid !== 1'b0) begin errors++; $display("FAIL gate_key_valid got %b want 0", key_valid); end
    if (busy      !== 1'b0) begin errors++; $display("FAIL gate_busy got %b want 0", busy); end
    in_valid = 1'b0;
    key_wr = 1'b1; key_half = 1'b0; key_in = 64'h0;
    tick();
    key_wr = 1'b0;
    checks += 2;
    if (in_ready  !== 1'b1) begin errors++; $display("FAIL gate_release_in_ready got %b want 1", in_ready); end
    if (key_valid !== 1'b1) begin errors++; $display("FAIL gate_release_key_valid got %b want 1", key_valid); end
  endtask

  task automatic test_zero_key();
    int n;
    in_valid = 1'b1; in_data = 64'h0A3AEA41_40A9BA94;
    tick();
    in_valid = 1'b0;
    checks += 2;
    if (busy     !== 1'b1) begin errors++; $display("FAIL kat_busy got %b want 1", busy); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL kat_in_ready got %b want 0", in_ready); end
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    checks += 2;
    if (n !== 32) begin errors++; $display("FAIL kat_latency got %0d want 32", n); end
    if (out_data !== 64'h0) begin errors++; $display("FAIL kat_data got %h want 0", out_data); end
    tick(); tick(); tick();
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL kat_hold_valid got %b want 1", out_valid); end
    if (out_data !== 64'h0) begin errors++; $display("FAIL kat_hold_data got %h want 0", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL kat_handshake_valid got %b want 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL kat_handshake_busy got %b want 0", busy); end
  endtask

  task automatic test_roundtrip();
    logic [127:0] k;
    logic [63:0]  pt, held;
    bit ok, done, seen, unstable;
    int cyc;
    for (int b = 0; b < 1000; b++) begin
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt = {$urandom(), $urandom()};
      write_key(k);
      accept_block(tea_enc(pt, k), ok);
      done = 0; seen = 0; unstable = 0; cyc = 0; held = '0;
      while (!done && cyc < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid) begin
          if (!seen) begin
            seen = 1; checks++;
            if (out_data !== pt) begin errors++; $display("FAIL rt_data blk %0d got %h want %h", b, out_data, pt); end
          end else if (out_data !== held) unstable = 1;
          held = out_data;
          if (out_ready) done = 1;
        end
        tick(); cyc++;
      end
      out_ready = 1'b0;
      checks++;
      if (!ok || !done || unstable)
        begin errors++; $display("FAIL rt_flow blk %0d accepted %b done %b unstable %b want 1 1 0", b, ok, done, unstable); end
    end
  endtask

  task automatic test_key_update();
    logic [127:0] ka, kb;
    logic [63:0]  pa, pb;
    bit ok;
    int n;
    ka = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    kb = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678;
    pa = 64'h0123_4567_89AB_CDEF;
    pb = 64'hFEDC_BA98_7654_3210;
    write_key(ka);
    // Key write coincident with the accept edge.
    in_valid = 1'b1; in_data = tea_enc(pa, ka);
    key_wr = 1'b1; key_half = 1'b1; key_in = kb[127:64];
    tick();
    in_valid = 1'b0; key_wr = 1'b0;
    tick(); tick(); tick(); tick();
    key_wr = 1'b1; key_half = 1'b0; key_in = kb[63:0];
    tick();
    key_wr = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    checks++;
    if (out_data !== pa) begin errors++; $display("FAIL keyupd_old got %h want %h", out_data, pa); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    accept_block(tea_enc(pb, kb), ok);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    checks++;
    if (!ok || out_data !== pb) begin errors++; $display("FAIL keyupd_new got %h want %h", out_data, pb); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok, saw;
    write_key(128'h1);
    accept_block(tea_enc(64'h55, 128'h1), ok);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks += 3;
    if (busy      !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_key_valid got %b want 0", key_valid); end
    if (in_ready  !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b want 0", in_ready); end
    saw = 0;
    for (int i = 0; i < 40; i++) begin if (out_valid) saw = 1; tick(); end
    checks++;
    if (saw) begin errors++; $display("FAIL rstmid_out_valid got 1 want 0"); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k;
    logic [63:0]  pt [3];
    int acc_t [3];
    int na, no, t;
    bit busy_bad;
    k = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    pt[0] = 64'h1111_2222_3333_4444;
    pt[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    pt[2] = 64'h0000_0000_FFFF_FFFF;
    write_key(k);
    out_ready = 1'b1;
    na = 0; no = 0; busy_bad = 0;
    in_valid = 1'b1; in_data = tea_enc(pt[0], k);
    for (t = 0; t < 150 && no < 3; t++) begin
      if (out_valid) begin
        checks++;
        if (out_data !== pt[no]) begin errors++; $display("FAIL b2b_data blk %0d got %h want %h", no, out_data, pt[no]); end
        no++;
      end
      if (na < 3 && !busy && !in_ready) busy_bad = 1;
      if (in_valid && in_ready) begin
        acc_t[na] = t; na++;
        tick();
        if (na < 3) in_data = tea_enc(pt[na], k); else in_valid = 1'b0;
      end else tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks += 4;
    if (na !== 3 || no !== 3) begin errors++; $display("FAIL b2b_count accepts %0d outputs %0d want 3 3", na, no); end
    if (na == 3 && acc_t[1] - acc_t[0] !== 34)
      begin errors++; $display("FAIL b2b_gap0 got %0d want 34", acc_t[1] - acc_t[0]); end
    if (na == 3 && acc_t[2] - acc_t[1] !== 34)
      begin errors++; $display("FAIL b2b_gap1 got %0d want 34", acc_t[2] - acc_t[1]); end
    if (busy_bad) begin errors++; $display("FAIL b2b_busy idle-without-ready got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_key_gating();
    test_zero_key();
    test_roundtrip();
    test_key_update();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tea_decrypt_iter.md
Name: tea_decrypt_iter

Overview:
- Iterative, multi-cycle TEA decryption core: one full TEA round per clock, 32 rounds by default.
- It is the receive-side counterpart of our combinational TEA encrypt path. It consumes ciphertext blocks and produces plaintext.
- Uses a valid/ready handshake on input and output, and a 128-bit key loaded in two 64-bit halves.
- Sits between a ciphertext source (link/FIFO) and the plaintext consumer. Trades throughput for a short critical path.

Parameters:
- ROUNDS, 32, number of TEA rounds. The initial sum is ROUNDS*DELTA mod 2^32 (0xC6EF3720 for 32).
- DELTA, 32'h9E3779B9, TEA key-schedule constant.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- key_in  in  64  key half data
- key_wr  in  1  write strobe for key_in
- key_half  in  1  1: write key[127:64]; 0: write key[63:0]
- key_valid  out  1  both key halves written since reset
- in_valid  in  1  ciphertext block valid
- in_ready  out  1  core can accept a block
- in_data  in  64  ciphertext, byte stream order
- out_valid  out  1  plaintext block valid
- out_ready  in  1  consumer accepts the block
- out_data  out  64  plaintext, byte stream order
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; key registers = 0; both half-written flags = 0; key_valid, in_ready, out_valid, busy = 0; out_data = 0; round counter = 0.
- Key load:
  - On any edge with key_wr=1, the selected half is written and its written flag is set.
  - key_valid = AND of the two flags.
  - Key writes are accepted in any state. The core latches a working copy of the key at block accept, so a write only affects the next block.
- Byte order:
  - Data and key are little-endian 32-bit words; each 32-bit word is byte-swapped on entry and exit.
  - After the swap: in_data[63:32] = v0, [31:0] = v1; key[127:96] = k0, [95:64] = k1, [63:32] = k2, [31:0] = k3.
- Round function: F(x, ka, kb, s) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb). Shifts are logical; all arithmetic is mod 2^32.
- FSM states:
  - IDLE: in_ready = key_valid. On in_valid & in_ready: latch the swapped v and the working key, set sum = ROUNDS*DELTA, cnt = 0, go to RUN.
  - RUN, one round per edge:
    - v1 -= F(v0, k2, k3, sum), then v0 -= F(new v1, k0, k1, sum); sum -= DELTA; cnt++.
    - On the edge where cnt reaches ROUNDS: register out_data = byteswapped {v0, v1}, set out_valid = 1, go to DONE.
  - DONE: out_valid and out_data are held stable until out_ready. On out_valid & out_ready: out_valid = 0, go to IDLE.
- Timing:
  - Latency: out_valid rises exactly ROUNDS cycles after the accept edge.
  - Throughput: one block per ROUNDS+2 cycles.
  - in_ready = 0 in RUN and DONE; there is no accept in the same cycle as an output handshake.
- Boundary conditions:
  - in_valid with key_valid = 0: not accepted; the block is held off by the source.
  - out_ready already high when DONE is entered: handshake completes on the first DONE edge.
  - rst in RUN/DONE: block is aborted and discarded, nothing is emitted, key is cleared.
  - out_data after the handshake: retains its last value; it is meaningful only while out_valid is high.
  - key_wr in the same cycle as accept: the latched working copy uses the pre-edge key.

Decomposition:
- Shared package tea_pkg:
  - DELTA constant and ROUNDS default.
  - Round function F.
  - Byte-swap helpers byteswap32, le32_blocks64, le32_blocks128.
- Sub-module tea_round_dec: combinational single decryption round, mapping {v, key, sum} to {v', sum-DELTA}. Reusable later for an unrolled/pipelined variant.

Test Plan:
- Zero-key known answer: write both halves = 0, in_data = 64'h0A3AEA41_40A9BA94 -> out_data = 64'h0 with out_valid rising exactly 32 cycles after accept.
- Round-trip: 1000 random key/plaintext pairs encrypted by the bench C TEA model, with random out_ready backpressure -> every out_data equals the original plaintext; out_data stable while out_valid & !out_ready.
- Key gating: in_valid=1 after rst with only key_half=1 written -> in_ready stays 0. Writing key_half=0 -> in_ready=1 next cycle.
- Key update during RUN: new key written mid-block -> current block decrypts with the old key; the next block uses the new key.
- Reset mid-operation: assert rst at RUN cycle 10 -> out_valid never asserts; key_valid=0; busy=0 next cycle.
- Back-to-back blocks with out_ready tied 1 -> accepts spaced exactly ROUNDS+2 cycles apart; busy low only on accept-cycle IDLE.
